// File: rtl/sdcard_cmd_responder_pkg.sv
// Shared types and constants for the card-side CMD line responder.
// Response codes, frame lengths and the response frame layout live here.
package sdcard_cmd_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RX,
      ST_WAIT,
      ST_TX
   } state_t;

   localparam logic [1:0] RSP_NONE = 2'd0;
   localparam logic [1:0] RSP_R1   = 2'd1;
   localparam logic [1:0] RSP_R2   = 2'd2;
   localparam logic [1:0] RSP_R3   = 2'd3;

   localparam logic [7:0] FRAME_SHORT = 8'd48;
   localparam logic [7:0] FRAME_LONG  = 8'd136;
   localparam logic [6:0] CRC7_POLY   = 7'h09;

   // Left-aligned response frame (bit 135 is the start bit); CRC field left zero,
   // the serialiser substitutes the running CRC7 there for R1/R2.
   function automatic logic [135:0] build_frame(input logic [1:0] rsp_type,
                                                input logic [119:0] rsp_data);
      case (rsp_type)
         RSP_R2:  build_frame = {2'b00, 6'h3F, rsp_data, 7'h00, 1'b1};
         RSP_R3:  build_frame = {2'b00, 6'h3F, rsp_data[31:0], 7'h7F, 1'b1, 88'h0};
         default: build_frame = {2'b00, rsp_data[37:32], rsp_data[31:0], 7'h00, 1'b1, 88'h0};
      endcase
   endfunction

endpackage

// File: rtl/sdcard_cmd_responder_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0): clear has priority, one bit per enabled cycle.
// Result valid the cycle after the last enabled bit; no flow control.
module sdcard_crc7
   import sdcard_cmd_responder_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);

   logic [6:0] crc_q;
   logic [6:0] crc_d;
   logic       fb;

   always_comb begin
      fb    = din ^ crc_q[6];
      crc_d = crc_q;
      if (clr) begin
         crc_d = 7'h00;
      end else if (en) begin
         crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= 7'h00;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sdcard_cmd_responder.sv
// Card-side CMD line: receive/validate 48-bit command, wait NCR ticks, send R1/R2/R3.
// o_cmd_valid/o_cmd_err pulse one cycle after the end-bit tick; responses are not backpressured.
module sdcard_cmd_responder
   import sdcard_cmd_responder_pkg::*;
#(
   parameter int NCR         = 2,
   parameter int RSP_TIMEOUT = 64,
   parameter bit OPT_CRC_CHK = 1'b1
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_ck_en,
   input  logic         i_cmd,
   output logic         o_cmd,
   output logic         o_cmd_oe,
   output logic         o_cmd_valid,
   output logic [5:0]   o_cmd_index,
   output logic [31:0]  o_cmd_arg,
   output logic         o_cmd_err,
   input  logic         i_rsp_valid,
   input  logic [1:0]   i_rsp_type,
   input  logic [119:0] i_rsp_data,
   output logic         o_busy
);

   localparam logic [7:0] NCR_T = 8'(NCR);
   localparam logic [7:0] TMO_T = 8'(RSP_TIMEOUT);

   state_t         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [45:0]    rx_sr_q, rx_sr_d;
   logic [135:0]   tx_sr_q, tx_sr_d;
   logic           rsp_lat_q, rsp_lat_d;
   logic [1:0]     rsp_type_q, rsp_type_d;
   logic [119:0]   rsp_data_q, rsp_data_d;
   logic           cmd_q, cmd_d;
   logic           oe_q, oe_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;
   logic [5:0]     index_q, index_d;
   logic [31:0]    arg_q, arg_d;

   logic           crc_clr, crc_en, crc_din;
   logic [6:0]     crc;
   logic [7:0]     cnt_nx, frame_len, crc_lo;
   logic [135:0]   tx_frame;
   logic [2:0]     crc_sel;
   logic           in_crc, tx_bit, rx_ok;

   assign cnt_nx    = cnt_q + 8'd1;
   assign frame_len = (rsp_type_q == RSP_R2) ? FRAME_LONG : FRAME_SHORT;
   assign crc_lo    = frame_len - 8'd8;
   assign tx_frame  = build_frame(rsp_type_q, rsp_data_q);
   // Both frame lengths are multiples of 8, so the low counter bits index the CRC field.
   assign crc_sel   = 3'd6 - cnt_nx[2:0];
   assign in_crc    = (rsp_type_q != RSP_R3) && (cnt_nx >= crc_lo) && (cnt_nx < frame_len - 8'd1);

   sdcard_crc7 u_crc7 (
      .clk   (i_clk),
      .rst_n (i_reset_n),
      .clr   (crc_clr),
      .en    (crc_en),
      .din   (crc_din),
      .crc   (crc)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_sr_d    = tx_sr_q;
      rsp_lat_d  = rsp_lat_q;
      rsp_type_d = rsp_type_q;
      rsp_data_d = rsp_data_q;
      cmd_d      = cmd_q;
      oe_d       = oe_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      index_d    = index_q;
      arg_d      = arg_q;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      crc_din    = i_cmd;
      tx_bit     = 1'b1;
      rx_ok      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cmd_d     = 1'b1;
            oe_d      = 1'b0;
            rsp_lat_d = 1'b0;
            if (i_ck_en && !i_cmd) begin
               state_d = ST_RX;
               cnt_d   = 8'd1;
               crc_clr = 1'b1;
            end
         end

         ST_RX: begin
            if (i_ck_en) begin
               crc_en  = (cnt_q <= 8'd39);
               cnt_d   = cnt_nx;
               rx_sr_d = {rx_sr_q[44:0], i_cmd};
               if (cnt_q == 8'd47) begin
                  rx_ok = rx_sr_q[45] && i_cmd && (!OPT_CRC_CHK || (rx_sr_q[6:0] == crc));
                  if (rx_ok) begin
                     index_d = rx_sr_q[44:39];
                     arg_d   = rx_sr_q[38:7];
                     valid_d = 1'b1;
                     state_d = ST_WAIT;
                     cnt_d   = 8'd0;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
         end

         ST_WAIT: begin
            if (!rsp_lat_q && i_rsp_valid && (i_rsp_type == RSP_NONE)) begin
               state_d = ST_IDLE;
            end else begin
               if (!rsp_lat_q && i_rsp_valid) begin
                  rsp_lat_d  = 1'b1;
                  rsp_type_d = i_rsp_type;
                  rsp_data_d = i_rsp_data;
               end
               if (i_ck_en) begin
                  cnt_d = cnt_nx;
                  if (rsp_lat_q && (cnt_nx >= NCR_T)) begin
                     state_d = ST_TX;
                     cnt_d   = 8'd0;
                     oe_d    = 1'b1;
                     cmd_d   = tx_frame[135];
                     tx_sr_d = {tx_frame[134:0], 1'b0};
                     crc_clr = 1'b1;
                  end else if (!rsp_lat_q && !i_rsp_valid && (cnt_nx >= TMO_T)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end

         ST_TX: begin
            if (i_ck_en) begin
               if (cnt_q == frame_len) begin
                  state_d = ST_IDLE;
                  oe_d    = 1'b0;
                  cmd_d   = 1'b1;
               end else begin
                  cnt_d   = cnt_nx;
                  tx_sr_d = {tx_sr_q[134:0], 1'b0};
                  if (cnt_nx >= frame_len) begin
                     tx_bit = 1'b1;
                  end else if (in_crc) begin
                     tx_bit = crc[crc_sel];
                  end else begin
                     tx_bit = tx_sr_q[135];
                  end
                  cmd_d   = tx_bit;
                  crc_din = tx_bit;
                  // R2 CRC covers only the 120 data bits after the 8-bit header.
                  crc_en  = (cnt_nx < crc_lo) && ((rsp_type_q == RSP_R1) || (cnt_nx >= 8'd8));
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         rx_sr_q    <= '0;
         tx_sr_q    <= '0;
         rsp_lat_q  <= 1'b0;
         rsp_type_q <= RSP_NONE;
         rsp_data_q <= '0;
         cmd_q      <= 1'b1;
         oe_q       <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         index_q    <= 6'd0;
         arg_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rx_sr_q    <= rx_sr_d;
         tx_sr_q    <= tx_sr_d;
         rsp_lat_q  <= rsp_lat_d;
         rsp_type_q <= rsp_type_d;
         rsp_data_q <= rsp_data_d;
         cmd_q      <= cmd_d;
         oe_q       <= oe_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         index_q    <= index_d;
         arg_q      <= arg_d;
      end
   end

   assign o_cmd       = cmd_q;
   assign o_cmd_oe    = oe_q;
   assign o_cmd_valid = valid_q;
   assign o_cmd_err   = err_q;
   assign o_cmd_index = index_q;
   assign o_cmd_arg   = arg_q;
   assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdcard_cmd_responder.sv
// Directed bench for sdcard_cmd_responder: host-side frames in, scoreboarded
// command events and response frames checked against a bench-side CRC7 model.
module tb_sdcard_cmd_responder;

   localparam int NCR         = 2;
   localparam int RSP_TIMEOUT = 64;

   logic         i_clk = 1'b0;
   logic         i_reset_n;
   logic         i_ck_en;
   logic         i_cmd;
   logic         o_cmd;
   logic         o_cmd_oe;
   logic         o_cmd_valid;
   logic [5:0]   o_cmd_index;
   logic [31:0]  o_cmd_arg;
   logic         o_cmd_err;
   logic         i_rsp_valid;
   logic [1:0]   i_rsp_type;
   logic [119:0] i_rsp_data;
   logic         o_busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          is_err;
      logic [5:0]  idx;
      logic [31:0] arg;
   } ev_t;

   ev_t          ev_q[$];
   logic [135:0] rsp_q[$];
   int           len_q[$];

   always #5 i_clk = ~i_clk;

   sdcard_cmd_responder #(
      .NCR         (NCR),
      .RSP_TIMEOUT (RSP_TIMEOUT),
      .OPT_CRC_CHK (1'b1)
   ) dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_ck_en     (i_ck_en),
      .i_cmd       (i_cmd),
      .o_cmd       (o_cmd),
      .o_cmd_oe    (o_cmd_oe),
      .o_cmd_valid (o_cmd_valid),
      .o_cmd_index (o_cmd_index),
      .o_cmd_arg   (o_cmd_arg),
      .o_cmd_err   (o_cmd_err),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_type  (i_rsp_type),
      .i_rsp_data  (i_rsp_data),
      .o_busy      (o_busy)
   );

   // Bit tick: high across every fourth rising edge of i_clk.
   initial begin
      i_ck_en = 1'b0;
      forever begin
         repeat (3) @(posedge i_clk);
         #2 i_ck_en = 1'b1;
         @(posedge i_clk);
         #2 i_ck_en = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = n - 1; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] h;
      h = {2'b01, idx, arg};
      return {h, crc7({80'h0, h}, 40), 1'b1};
   endfunction

   function automatic logic [135:0] rsp_frame(input logic [1:0] t, input logic [119:0] d);
      logic [39:0] h;
      h = {2'b00, d[37:32], d[31:0]};
      case (t)
         2'd1:    return {h, crc7({80'h0, h}, 40), 1'b1, 88'h0};
         2'd3:    return {2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1, 88'h0};
         default: return {2'b00, 6'h3F, d, crc7(d, 120), 1'b1};
      endcase
   endfunction

   task automatic push_ev(input bit is_err, input logic [5:0] idx, input logic [31:0] arg);
      ev_t e;
      e.is_err = is_err;
      e.idx    = idx;
      e.arg    = arg;
      ev_q.push_back(e);
   endtask

   // Command event monitor: every valid/err pulse must match the next expected event.
   always @(negedge i_clk) begin
      if (i_reset_n === 1'b1 && (o_cmd_valid === 1'b1 || o_cmd_err === 1'b1)) begin
         check("ev_expected", (ev_q.size() > 0), 1'b1);
         if (ev_q.size() > 0) begin
            ev_t e;
            e = ev_q.pop_front();
            check("ev_kind", {o_cmd_err, o_cmd_valid}, e.is_err ? 2'b10 : 2'b01);
            if (!e.is_err) begin
               check("ev_index", o_cmd_index, e.idx);
               check("ev_arg", o_cmd_arg, e.arg);
            end
         end
      end
   end

   task automatic send_cmd(input logic [47:0] f);
      for (int i = 47; i >= 0; i--) begin
         @(posedge i_ck_en);
         i_cmd = f[i];
      end
      @(posedge i_clk);
      @(negedge i_clk);
      i_cmd = 1'b1;
   endtask

   task automatic give_rsp(input logic [1:0] t, input logic [119:0] d, input bit push);
      i_rsp_valid = 1'b1;
      i_rsp_type  = t;
      i_rsp_data  = d;
      if (push) begin
         rsp_q.push_back(rsp_frame(t, d));
         len_q.push_back((t == 2'd2) ? 136 : 48);
      end
      @(negedge i_clk);
      i_rsp_valid = 1'b0;
   endtask

   task automatic check_response(input string tag, output logic [135:0] got);
      int           released;
      bit           seen;
      int           len;
      logic [135:0] exp_f;
      logic         oe_all;
      released = 0;
      seen     = 1'b0;
      got      = '0;
      check({tag, "_sb_nonempty"}, (rsp_q.size() > 0), 1'b1);
      if (rsp_q.size() == 0) return;
      exp_f = rsp_q.pop_front();
      len   = len_q.pop_front();
      for (int t = 0; t < 300 && !seen; t++) begin
         @(posedge i_ck_en);
         if (o_cmd_oe === 1'b1) seen = 1'b1;
         else released++;
      end
      check({tag, "_start_seen"}, seen, 1'b1);
      if (!seen) return;
      check({tag, "_ncr_gap"}, (released >= NCR && released <= NCR + 2), 1'b1);
      got[135] = o_cmd;
      oe_all   = 1'b1;
      for (int i = 1; i < len; i++) begin
         @(posedge i_ck_en);
         got[135-i] = o_cmd;
         oe_all     = oe_all & o_cmd_oe;
      end
      check({tag, "_frame"}, got, exp_f);
      check({tag, "_oe_held"}, oe_all, 1'b1);
      @(posedge i_ck_en);
      check({tag, "_idle_one"}, {o_cmd_oe, o_cmd}, 2'b11);
      @(posedge i_ck_en);
      check({tag, "_released"}, {o_cmd_oe, o_cmd}, 2'b01);
      check({tag, "_idle"}, o_busy, 1'b0);
   endtask

   initial begin
      logic [135:0] got;
      logic [119:0] r2_data;
      logic         any_oe;
      int           busy_ticks;
      bit           seen;

      i_reset_n   = 1'b0;
      i_cmd       = 1'b1;
      i_rsp_valid = 1'b0;
      i_rsp_type  = 2'd0;
      i_rsp_data  = '0;
      repeat (3) @(negedge i_clk);
      check("rst_cmd", o_cmd, 1'b1);
      check("rst_oe", o_cmd_oe, 1'b0);
      check("rst_valid_err", {o_cmd_valid, o_cmd_err}, 2'b00);
      check("rst_index_arg", {o_cmd_index, o_cmd_arg}, 38'h0);
      check("rst_busy", o_busy, 1'b0);
      i_reset_n = 1'b1;
      repeat (2) @(negedge i_clk);

      // CMD0, then "no response" returns to IDLE at once.
      push_ev(1'b0, 6'd0, 32'h0);
      send_cmd(48'h40_0000_0000_95);
      give_rsp(2'd0, '0, 1'b0);
      check("cmd0_none_idle", o_busy, 1'b0);
      check("cmd0_none_oe", o_cmd_oe, 1'b0);

      // CMD8 + R1; a second valid in WAIT must be ignored.
      push_ev(1'b0, 6'd8, 32'h0000_01AA);
      send_cmd(48'h48_0000_01AA_87);
      give_rsp(2'd1, {82'h0, 6'd8, 32'h0000_01AA}, 1'b1);
      give_rsp(2'd3, {88'h0, 32'hDEAD_BEEF}, 1'b0);
      check_response("cmd8_r1", got);
      check("cmd8_r1_crc", got[95:89], crc7({80'h0, 2'b00, 6'd8, 32'h0000_01AA}, 40));

      // CMD55 with corrupted CRC byte: error pulse, held outputs, line untouched.
      push_ev(1'b1, 6'd0, 32'h0);
      send_cmd(48'h77_0000_0000_67);
      check("cmd55_hold", {o_cmd_index, o_cmd_arg}, {6'd8, 32'h0000_01AA});
      give_rsp(2'd1, {82'h0, 6'd55, 32'h1234_5678}, 1'b0);
      any_oe = 1'b0;
      for (int t = 0; t < 12; t++) begin
         @(posedge i_ck_en);
         any_oe = any_oe | o_cmd_oe;
      end
      check("cmd55_line_free", any_oe, 1'b0);
      check("cmd55_idle", o_busy, 1'b0);

      // CMD2 + R2 (136 bits, CRC over data only).
      r2_data = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
      push_ev(1'b0, 6'd2, 32'h0);
      send_cmd(cmd_frame(6'd2, 32'h0));
      give_rsp(2'd2, r2_data, 1'b1);
      check_response("cmd2_r2", got);
      check("cmd2_r2_lead", got[135:128], 8'h3F);
      check("cmd2_r2_crc", got[7:1], crc7(r2_data, 120));

      // CMD1 + R3: index and CRC fields all ones.
      push_ev(1'b0, 6'd1, 32'h40FF_8000);
      send_cmd(cmd_frame(6'd1, 32'h40FF_8000));
      give_rsp(2'd3, {88'h0, 32'h80FF_8000}, 1'b1);
      check_response("cmd1_r3", got);
      check("cmd1_r3_ones", {got[133:128], got[95:89]}, 13'h1FFF);

      // No response: drop back to IDLE after the timeout, silently.
      push_ev(1'b0, 6'd0, 32'h0);
      send_cmd(48'h40_0000_0000_95);
      busy_ticks = 0;
      seen       = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(posedge i_ck_en);
         if (o_busy === 1'b1) busy_ticks++;
         else seen = 1'b1;
      end
      check("timeout_idle", seen, 1'b1);
      check("timeout_len", (busy_ticks >= RSP_TIMEOUT - 1 && busy_ticks <= RSP_TIMEOUT + 2), 1'b1);
      check("timeout_line_free", o_cmd_oe, 1'b0);

      // Reset in the middle of an R2 response releases the line immediately.
      push_ev(1'b0, 6'd2, 32'h0);
      send_cmd(cmd_frame(6'd2, 32'h0));
      give_rsp(2'd2, r2_data, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(posedge i_ck_en);
         if (o_cmd_oe === 1'b1) seen = 1'b1;
      end
      repeat (10) @(posedge i_ck_en);
      check("midtx_driving", o_cmd_oe, 1'b1);
      #2 i_reset_n = 1'b0;
      #2;
      check("midtx_rst_line", {o_cmd_oe, o_cmd}, 2'b01);
      check("midtx_rst_state", {o_busy, o_cmd_index}, 7'h0);
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
      repeat (2) @(negedge i_clk);

      // Responder is usable again after reset.
      push_ev(1'b0, 6'd0, 32'h0);
      send_cmd(48'h40_0000_0000_95);
      give_rsp(2'd0, '0, 1'b0);
      check("post_rst_idle", o_busy, 1'b0);

      repeat (8) @(negedge i_clk);
      check("ev_drained", ev_q.size(), 0);
      check("rsp_drained", rsp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
